// File: rtl/regfile_param.sv
// Parameterised register file with byte-masked writes, optional write-to-read bypass
// and a sequenced clear engine that zeroes one register per cycle.
module regfile_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [WIDTH/8-1:0] WriteMask,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic              ClearReq,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam int unsigned NBytes = WIDTH / 8;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  mem_q [Depth];
  logic [WIDTH-1:0]  mem_d [Depth];

  logic busy;
  logic byp_en;
  logic wr_en;

  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0]  old_val,
                                                   input logic [WIDTH-1:0]  new_val,
                                                   input logic [NBytes-1:0] mask);
    logic [WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < NBytes; b++) begin
      if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign busy   = (state_q == StClear);
  assign byp_en = RegWrite && !busy;
  assign wr_en  = RegWrite && !busy && !(ZERO_REG && (WriteRegister == '0));

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

  // Next-state logic; ClearReq is only looked at while idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ClearReq) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Array update: the clear engine owns the array while busy, user writes are dropped
  always_comb begin
    mem_d = mem_q;
    if (busy) begin
      mem_d[cnt_q] = '0;
    end else if (wr_en) begin
      mem_d[WriteRegister] = merge_bytes(mem_q[WriteRegister], WriteData, WriteMask);
    end
  end

  // Outputs
  always_comb begin
    Busy = busy;
    Done = done_q;
  end

  always_comb begin
    ReadData1 = mem_q[ReadRegister1];
    if (BYPASS && byp_en && (ReadRegister1 == WriteRegister)) begin
      ReadData1 = merge_bytes(mem_q[ReadRegister1], WriteData, WriteMask);
    end
    if (ZERO_REG && (ReadRegister1 == '0)) ReadData1 = '0;
  end

  always_comb begin
    ReadData2 = mem_q[ReadRegister2];
    if (BYPASS && byp_en && (ReadRegister2 == WriteRegister)) begin
      ReadData2 = merge_bytes(mem_q[ReadRegister2], WriteData, WriteMask);
    end
    if (ZERO_REG && (ReadRegister2 == '0)) ReadData2 = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (zero-reg+bypass, and plain) share stimulus and are
// compared against an array-based reference model.
module tb_regfile_param;

  localparam int D = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wd;
  logic [3:0]  wm;
  logic [4:0]  wa, ra1, ra2;
  logic        we, clr;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy_a, done_a, busy_b, done_b;

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_a (
    .Clk(clk), .Reset_n(rst_n), .WriteData(wd), .WriteMask(wm), .WriteRegister(wa),
    .RegWrite(we), .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(rd1_a),
    .ReadData2(rd2_a), .ClearReq(clr), .Busy(busy_a), .Done(done_a)
  );

  regfile_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_b (
    .Clk(clk), .Reset_n(rst_n), .WriteData(wd), .WriteMask(wm), .WriteRegister(wa),
    .RegWrite(we), .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(rd1_b),
    .ReadData2(rd2_b), .ClearReq(clr), .Busy(busy_b), .Done(done_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: stored contents plus remaining clear work
  logic [31:0] ref_a [D];
  logic [31:0] ref_b [D];
  bit          clr_on;
  int          clr_idx;
  bit          done_exp;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_a(input logic [4:0] addr);
    if (addr == 0) return 32'h0;
    if (we && !clr_on && addr == wa) return merge(ref_a[addr], wd, wm);
    return ref_a[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      ref_a[i] = '0;
      ref_b[i] = '0;
    end
    clr_on   = 1'b0;
    clr_idx  = 0;
    done_exp = 1'b0;
  endtask

  task automatic model_edge();
    bit fin;
    fin = 1'b0;
    if (clr_on) begin
      ref_a[clr_idx] = '0;
      ref_b[clr_idx] = '0;
      if (clr_idx == D - 1) begin
        clr_on = 1'b0;
        fin    = 1'b1;
      end else begin
        clr_idx++;
      end
    end else begin
      if (we) begin
        if (wa != 0) ref_a[wa] = merge(ref_a[wa], wd, wm);
        ref_b[wa] = merge(ref_b[wa], wd, wm);
      end
      if (clr) begin
        clr_on  = 1'b1;
        clr_idx = 0;
      end
    end
    done_exp = fin;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_rd1a"}, rd1_a, exp_a(ra1));
    check_val({tag, "_rd2a"}, rd2_a, exp_a(ra2));
    check_val({tag, "_rd1b"}, rd1_b, ref_b[ra1]);
    check_val({tag, "_rd2b"}, rd2_b, ref_b[ra2]);
    check_val({tag, "_busya"}, {31'b0, busy_a}, {31'b0, clr_on});
    check_val({tag, "_donea"}, {31'b0, done_a}, {31'b0, done_exp});
    check_val({tag, "_busyb"}, {31'b0, busy_b}, {31'b0, clr_on});
    check_val({tag, "_doneb"}, {31'b0, done_b}, {31'b0, done_exp});
  endtask

  // Inputs are already set; check pre-edge outputs, take the edge, settle
  task automatic cycle(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we  = 1'b0;
    clr = 1'b0;
    wm  = 4'h0;
    wd  = '0;
    wa  = '0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1;
    wa = a;
    wd = d;
    wm = m;
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    ra1 = '0;
    ra2 = '0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_reset");

    // Basic write, both ports
    write(5'd2, 32'h0000_002A, 4'hF);
    ra1 = 5'd2;
    ra2 = 5'd2;
    cycle("w2");
    idle_inputs();
    #1;
    check_val("w2_rd1", rd1_a, 32'h0000_002A);
    check_val("w2_rd2", rd2_a, 32'h0000_002A);

    // Byte mask merge
    write(5'd4, 32'h1122_3344, 4'hF);
    cycle("w4a");
    write(5'd4, 32'hAABB_CCDD, 4'h5);
    cycle("w4b");
    idle_inputs();
    ra1 = 5'd4;
    #1;
    check_val("mask_rd1", rd1_a, 32'h11BB_33DD);
    check_val("mask_rd1b", rd1_b, 32'h11BB_33DD);

    // RegWrite low, and writes to other registers
    we = 1'b0; wa = 5'd5; wd = 32'd27; wm = 4'hF; ra1 = 5'd5;
    cycle("nowe");
    check_val("nowe_r5", rd1_a, 32'h0);
    write(5'd25, 32'hCAFE_0025, 4'hF);
    cycle("w25");
    write(5'd1, 32'h0000_0001, 4'hF);
    ra2 = 5'd25;
    cycle("w1");
    idle_inputs();
    #1;
    check_val("r25_hold", rd2_a, 32'hCAFE_0025);

    // Zero register under bypass
    write(5'd0, 32'd59, 4'hF);
    ra1 = 5'd0;
    #1;
    check_val("zero_before", rd1_a, 32'h0);
    cycle("zero");
    idle_inputs();
    #1;
    check_val("zero_after", rd1_a, 32'h0);
    check_val("nozero_after", rd1_b, 32'd59);

    // Bypass vs no bypass
    write(5'd7, 32'h0000_0055, 4'hF);
    ra2 = 5'd7;
    #1;
    check_val("byp_before", rd2_a, 32'h55);
    check_val("nobyp_before", rd2_b, 32'h0);
    cycle("byp");
    idle_inputs();
    #1;
    check_val("nobyp_after", rd2_b, 32'h55);

    // Fill and clear
    for (int i = 1; i < D; i++) begin
      write(5'(i), $urandom | 32'h1, 4'hF);
      cycle("fill");
    end
    idle_inputs();
    clr = 1'b1;
    cycle("clr_req");
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      idle_inputs();
      if (k == 5) begin
        write(5'd3, 32'hFFFF_FFFF, 4'hF);
        clr = 1'b1;
        ra1 = 5'd3;
      end
      #1;
      if (busy_a) busy_cnt++;
      if (done_a) done_cnt++;
      cycle("clr_run");
    end
    check_val("busy_len", busy_cnt, 32'd32);
    check_val("done_pulses", done_cnt, 32'd1);
    for (int i = 0; i < D; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(i);
      #1;
      check_val("cleared_a", rd1_a, 32'h0);
      check_val("cleared_b", rd2_b, 32'h0);
    end

    // Reset in the middle of a clear
    for (int i = 0; i < 10; i++) begin
      write(5'($urandom_range(1, D - 1)), $urandom | 32'h1, 4'hF);
      cycle("fill2");
    end
    idle_inputs();
    clr = 1'b1;
    cycle("clr2_req");
    clr = 1'b0;
    for (int k = 0; k < 10; k++) cycle("clr2_run");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_busy", {31'b0, busy_a}, 32'h0);
    check_val("rst_done", {31'b0, done_a}, 32'h0);
    for (int i = 0; i < D; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(i);
      #1;
      check_val("rst_clr_a", rd1_a, 32'h0);
      check_val("rst_clr_b", rd2_b, 32'h0);
    end
    write(5'd9, 32'h1234_5678, 4'hF);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    ra1 = 5'd9;
    ra2 = 5'd9;
    for (int k = 0; k < 5; k++) cycle("after_rst");

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, D - 1));
      wd  = $urandom;
      wm  = 4'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, D - 1));
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, D - 1));
      clr = ($urandom_range(0, 59) == 0);
      if (done_exp && $urandom_range(0, 1) == 1) clr = 1'b1;
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
